// File: rtl/spi_tx_responder_if.sv
// ----------------------------------------------------------------------------
// spi_tx_responder_if
// Word handshake between on-chip logic (master) and the SPI transmitter
// (slave).
//   tx_data   master -> slave  word to send
//   tx_valid  master -> slave  tx_data offered
//   tx_ready  slave  -> master holding register empty
// ----------------------------------------------------------------------------
interface spi_tx_responder_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/spi_tx_responder.sv
// ----------------------------------------------------------------------------
// spi_tx_responder
// SPI target-side transmitter (mode 0). Holds one word from on-chip logic and
// shifts it out MSB-first on miso during the next cs-low frame. sck and cs are
// oversampled in the clk domain; nothing is clocked by sck.
//
// Optional feature macro: SPI_TX_PARITY_EN appends an even-parity bit after
// the LSB (frame becomes DATA_WIDTH+1 bits).
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   sck_i       in   SPI clock from host (asynchronous)
//   cs_i        in   SPI chip select, active-low (asynchronous)
//   tx_if       slave modport: tx_data / tx_valid / tx_ready handshake
//   miso_o      out  serial data to host
//   miso_oe_o   out  miso drive enable, high while synchronized cs is low
//   busy_o      out  frame in progress
//   tx_done_o   out  1-clk pulse: all frame bits were sampled by the host
//   tx_abort_o  out  1-clk pulse: cs rose before the frame completed
//   underrun_o  out  1-clk pulse: frame started with holding register empty
// ----------------------------------------------------------------------------
module spi_tx_responder #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sck_i,
    input  logic               cs_i,
    spi_tx_responder_if.slave  tx_if,
    output logic               miso_o,
    output logic               miso_oe_o,
    output logic               busy_o,
    output logic               tx_done_o,
    output logic               tx_abort_o,
    output logic               underrun_o
);

`ifdef SPI_TX_PARITY_EN
    localparam int FRAME_BITS = DATA_WIDTH + 1;
`else
    localparam int FRAME_BITS = DATA_WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Synchronizers idle at sck=0, cs=1 so reset release creates no edges.
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   sck_dly_q;
    logic                   cs_dly_q;

    state_t                 state_q;
    logic [FRAME_BITS-1:0]  shift_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DATA_WIDTH-1:0]  hold_q;
    logic                   hold_full_q;
    logic                   miso_q;
    logic                   miso_oe_q;
    logic                   busy_q;
    logic                   tx_done_q;
    logic                   tx_abort_q;
    logic                   underrun_q;

    logic                   sck_s;
    logic                   cs_s;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   accept;
    logic [CNT_W-1:0]       cnt_d;
    logic [FRAME_BITS-1:0]  load_d;
    logic [FRAME_BITS-1:0]  shift_d;

    // Frame image of a data word; the parity bit trails the LSB.
    function automatic logic [FRAME_BITS-1:0] frame_word(input logic [DATA_WIDTH-1:0] d);
`ifdef SPI_TX_PARITY_EN
        return {d, ^d};
`else
        return d;
`endif
    endfunction

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_dly_q;
    assign sck_fall = ~sck_s & sck_dly_q;
    assign cs_fall  = ~cs_s & cs_dly_q;
    assign cs_rise  = cs_s & ~cs_dly_q;

    assign accept   = tx_if.tx_valid & ~hold_full_q;
    assign cnt_d    = cnt_q + 1'b1;
    // Underrun frames carry all zeros, including the parity bit.
    assign load_d   = hold_full_q ? frame_word(hold_q) : '0;
    assign shift_d  = {shift_q[FRAME_BITS-2:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q <= '0;
            cs_sync_q  <= '1;
            sck_dly_q  <= 1'b0;
            cs_dly_q   <= 1'b1;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
            sck_dly_q  <= sck_s;
            cs_dly_q   <= cs_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            tx_done_q   <= 1'b0;
            tx_abort_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            tx_done_q  <= 1'b0;
            tx_abort_q <= 1'b0;
            underrun_q <= 1'b0;
            miso_oe_q  <= ~cs_s;

            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        shift_q     <= load_d;
                        miso_q      <= load_d[FRAME_BITS-1];
                        cnt_q       <= '0;
                        hold_full_q <= 1'b0;
                        underrun_q  <= ~hold_full_q;
                        busy_q      <= 1'b1;
                        state_q     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // cs rise beats a coincident final sck rise.
                    if (cs_rise) begin
                        tx_abort_q <= 1'b1;
                        miso_q     <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else if (sck_rise) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == LAST_CNT) begin
                            tx_done_q <= 1'b1;
                            miso_q    <= 1'b0;
                            state_q   <= ST_DRAIN;
                        end
                    end else if (sck_fall) begin
                        shift_q <= shift_d;
                        miso_q  <= shift_d[FRAME_BITS-1];
                    end
                end
                ST_DRAIN: begin
                    miso_q <= 1'b0;
                    if (cs_rise) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    miso_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase

            // Placed after the FSM so an accept coinciding with the cs-fall
            // load (hold was empty) becomes the next word.
            if (accept) begin
                hold_q      <= tx_if.tx_data;
                hold_full_q <= 1'b1;
            end
        end
    end

    assign tx_if.tx_ready = ~hold_full_q;
    assign miso_o         = miso_q;
    assign miso_oe_o      = miso_oe_q;
    assign busy_o         = busy_q;
    assign tx_done_o      = tx_done_q;
    assign tx_abort_o     = tx_abort_q;
    assign underrun_o     = underrun_q;

endmodule

// File: tb/tb_spi_tx_responder.sv
// ----------------------------------------------------------------------------
// tb_spi_tx_responder
// Directed bench for spi_tx_responder: drives a mode-0 host at clk/8 and
// compares sampled miso words and event pulses with hand-computed values.
// ----------------------------------------------------------------------------
module tb_spi_tx_responder;

`ifdef SPI_TX_PARITY_EN
    localparam int FB = 17;
`else
    localparam int FB = 16;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sck = 1'b0;
    logic cs = 1'b1;
    logic miso, miso_oe, busy, tx_done, tx_abort, underrun;

    int total = 0;
    int bad = 0;
    int n_done = 0;
    int n_abort = 0;
    int n_under = 0;

    spi_tx_responder_if #(.DATA_WIDTH(16)) tx_if ();

    spi_tx_responder #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sck_i      (sck),
        .cs_i       (cs),
        .tx_if      (tx_if),
        .miso_o     (miso),
        .miso_oe_o  (miso_oe),
        .busy_o     (busy),
        .tx_done_o  (tx_done),
        .tx_abort_o (tx_abort),
        .underrun_o (underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_done)  n_done  <= n_done + 1;
        if (tx_abort) n_abort <= n_abort + 1;
        if (underrun) n_under <= n_under + 1;
    end

    // Expected frame for a full word in this build (parity appended if enabled).
    function automatic logic [31:0] exp_frame(input logic [15:0] d);
`ifdef SPI_TX_PARITY_EN
        return {15'd0, d, ^d};
`else
        return {16'd0, d};
`endif
    endfunction

    task automatic load_word(input logic [15:0] d);
        @(negedge clk);
        tx_if.tx_data  = d;
        tx_if.tx_valid = 1'b1;
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
    endtask

    // Host frame: cs low, nb sck pulses (sample on rise), optional cs release.
    task automatic run_frame(input int nb, input bit release_cs, output logic [31:0] bits,
                             output logic rdy, output logic oe, output logic bsy);
        bits = '0;
        @(negedge clk);
        cs = 1'b0;
        repeat (5) @(negedge clk);
        rdy = tx_if.tx_ready;
        oe  = miso_oe;
        bsy = busy;
        for (int i = 0; i < nb; i++) begin
            bits = {bits[30:0], miso};
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
            repeat (4) @(negedge clk);
        end
        if (release_cs) begin
            cs = 1'b1;
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #2;
        total++; if (miso !== 1'b0)    begin bad++; $display("FAIL reset_miso got=%b want=0", miso); end
        total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b want=0", miso_oe); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (tx_if.tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", tx_if.tx_ready); end
        total++; if ({tx_done, tx_abort, underrun} !== 3'b000)
            begin bad++; $display("FAIL reset_pulses got=%b want=000", {tx_done, tx_abort, underrun}); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic;
        logic [31:0] bits; logic rdy, oe, bsy; int d0, u0;
        load_word(16'hA5C3);
        total++; if (tx_if.tx_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_full got=%b want=0", tx_if.tx_ready); end
        d0 = n_done; u0 = n_under;
        run_frame(FB, 1'b1, bits, rdy, oe, bsy);
        total++; if (bits !== exp_frame(16'hA5C3)) begin bad++; $display("FAIL basic_data got=%h want=%h", bits, exp_frame(16'hA5C3)); end
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL basic_ready_after_fall got=%b want=1", rdy); end
        total++; if (oe !== 1'b1)  begin bad++; $display("FAIL basic_oe got=%b want=1", oe); end
        total++; if (bsy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", bsy); end
        total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL basic_done got=%0d want=1", n_done - d0); end
        total++; if (n_under - u0 !== 0) begin bad++; $display("FAIL basic_underrun got=%0d want=0", n_under - u0); end
        total++; if ({busy, miso_oe} !== 2'b00) begin bad++; $display("FAIL basic_idle got=%b want=00", {busy, miso_oe}); end
    endtask

    task automatic test_underrun;
        logic [31:0] bits; logic rdy, oe, bsy; int d0, u0;
        d0 = n_done; u0 = n_under;
        run_frame(FB, 1'b1, bits, rdy, oe, bsy);
        total++; if (bits !== 32'd0) begin bad++; $display("FAIL under_data got=%h want=0", bits); end
        total++; if (n_under - u0 !== 1) begin bad++; $display("FAIL under_pulse got=%0d want=1", n_under - u0); end
        total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL under_done got=%0d want=1", n_done - d0); end
    endtask

    task automatic test_abort;
        logic [31:0] bits; logic rdy, oe, bsy; int d0, a0, u0;
        load_word(16'hFFFF);
        d0 = n_done; a0 = n_abort;
        run_frame(7, 1'b1, bits, rdy, oe, bsy);
        total++; if (bits !== 32'h7F) begin bad++; $display("FAIL abort_data got=%h want=7f", bits); end
        total++; if (n_abort - a0 !== 1) begin bad++; $display("FAIL abort_pulse got=%0d want=1", n_abort - a0); end
        total++; if (n_done - d0 !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", n_done - d0); end
        u0 = n_under;
        run_frame(FB, 1'b1, bits, rdy, oe, bsy);
        total++; if (n_under - u0 !== 1) begin bad++; $display("FAIL abort_requeue got=%0d want=1", n_under - u0); end
        total++; if (bits !== 32'd0) begin bad++; $display("FAIL abort_next_data got=%h want=0", bits); end
    endtask

    task automatic test_hold_full;
        logic [31:0] bits; logic rdy, oe, bsy; int u0;
        load_word(16'h1234);
        @(negedge clk);
        tx_if.tx_data  = 16'h5678;
        tx_if.tx_valid = 1'b1;
        total++; if (tx_if.tx_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", tx_if.tx_ready); end
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 16'h0000;
        run_frame(FB, 1'b1, bits, rdy, oe, bsy);
        total++; if (bits !== exp_frame(16'h1234)) begin bad++; $display("FAIL full_data got=%h want=%h", bits, exp_frame(16'h1234)); end
        u0 = n_under;
        run_frame(FB, 1'b1, bits, rdy, oe, bsy);
        total++; if (n_under - u0 !== 1) begin bad++; $display("FAIL full_not_taken got=%0d want=1", n_under - u0); end
    endtask

    task automatic test_overclock;
        logic [31:0] bits; logic rdy, oe, bsy; int d0;
        load_word(16'h8001);
        d0 = n_done;
        run_frame(20, 1'b1, bits, rdy, oe, bsy);
        // 0x8001 then zeros (parity of 0x8001 is 0, so both builds match).
        total++; if (bits !== 32'h80010) begin bad++; $display("FAIL over_data got=%h want=80010", bits); end
        total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL over_done got=%0d want=1", n_done - d0); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] bits; logic rdy, oe, bsy; int u0;
        load_word(16'hBEEF);
        run_frame(5, 1'b0, bits, rdy, oe, bsy);
        load_word(16'h0F0F);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL rmid_oe got=%b want=0", miso_oe); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
        total++; if (tx_if.tx_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b want=1", tx_if.tx_ready); end
        cs = 1'b1;
        sck = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        u0 = n_under;
        run_frame(FB, 1'b1, bits, rdy, oe, bsy);
        total++; if (n_under - u0 !== 1) begin bad++; $display("FAIL rmid_hold_lost got=%0d want=1", n_under - u0); end
    endtask

`ifdef SPI_TX_PARITY_EN
    task automatic test_parity;
        logic [31:0] bits; logic rdy, oe, bsy;
        load_word(16'h0007);
        run_frame(17, 1'b1, bits, rdy, oe, bsy);
        total++; if (bits !== 32'h0000F) begin bad++; $display("FAIL par_odd got=%h want=0000f", bits); end
        load_word(16'h0003);
        run_frame(17, 1'b1, bits, rdy, oe, bsy);
        total++; if (bits !== 32'h00006) begin bad++; $display("FAIL par_even got=%h want=00006", bits); end
    endtask
`endif

    initial begin
        tx_if.tx_data  = 16'h0000;
        tx_if.tx_valid = 1'b0;
        test_reset();
        test_basic();
        test_underrun();
        test_abort();
        test_hold_full();
        test_overclock();
        test_reset_mid();
`ifdef SPI_TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
